// File: rtl/led_meter.sv
// ---------------------------------------------------------------------------
// led_meter
//
// Peak-hold level meter feeding the LED driver. On every rising edge of
// i_sample_clk the eight channel inputs are snapshotted and then walked one
// channel per clock through a shared magnitude / compare / decay datapath.
// When all eight channels have been updated, the top eight magnitude bits of
// every peak are published to the LED outputs at once. The LEDs therefore
// never show a half-updated frame.
//
// Optional feature macro: LED_METER_PEAK_HOLD_EN
//   defined   : each channel keeps a hold counter. A new peak is held for
//               HOLD_SAMPLES sample periods before it starts to decay.
//   undefined : no hold counters are built and HOLD_SAMPLES has no effect.
//               A peak decays on every sample period in which the new
//               magnitude is below it.
//
// Parameters:
//   W            sample width in bits (signed two's complement, W >= 9)
//   HOLD_SAMPLES sample periods a new peak is held (hold build only)
//   DECAY_SHIFT  decay per period = peak >> DECAY_SHIFT, minimum 1
//
// Ports:
//   i_clk         system clock
//   i_rst         synchronous active-high reset
//   i_sample_clk  sample-rate level signal in the i_clk domain
//   i_in0..i_in7  signed samples (0..3 calibrated inputs, 4..7 outputs)
//   o_led0..o_led7 unsigned 8-bit brightness per channel
//   o_busy        high while a scan or commit is in progress
//   o_overrun     sticky flag: a sample edge arrived while one was pending
// ---------------------------------------------------------------------------
module led_meter #(
  parameter int W            = 16,
  parameter int HOLD_SAMPLES = 4800,
  parameter int DECAY_SHIFT  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_sample_clk,
  input  logic signed [W-1:0] i_in0,
  input  logic signed [W-1:0] i_in1,
  input  logic signed [W-1:0] i_in2,
  input  logic signed [W-1:0] i_in3,
  input  logic signed [W-1:0] i_in4,
  input  logic signed [W-1:0] i_in5,
  input  logic signed [W-1:0] i_in6,
  input  logic signed [W-1:0] i_in7,
  output logic [7:0]          o_led0,
  output logic [7:0]          o_led1,
  output logic [7:0]          o_led2,
  output logic [7:0]          o_led3,
  output logic [7:0]          o_led4,
  output logic [7:0]          o_led5,
  output logic [7:0]          o_led6,
  output logic [7:0]          o_led7,
  output logic                o_busy,
  output logic                o_overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } meterState_t;

  meterState_t r_state;
  meterState_t w_nextState;

  logic                r_sampleClkQ;
  logic                r_pending;
  logic                r_overrun;
  logic [2:0]          r_idx;
  logic signed [W-1:0] r_snap [8];
  logic [W-2:0]        r_peak [8];
  logic [7:0]          r_led  [8];

  logic                w_rise;
  logic                w_capture;
  logic signed [W-1:0] w_x;
  logic [W-2:0]        w_negLow;
  logic [W-2:0]        w_mag;
  logic [W-2:0]        w_peakCur;
  logic [W-2:0]        w_shift;
  logic [W-2:0]        w_step;
  logic [W-2:0]        w_decayed;

`ifdef LED_METER_PEAK_HOLD_EN
  localparam int HW = $clog2(HOLD_SAMPLES + 1);
  logic [HW-1:0] r_hold [8];
`else
  // The hold length has no effect when hold counters are not built.
  localparam int unusedHoldSamples = HOLD_SAMPLES;
`endif

  assign w_rise    = i_sample_clk & ~r_sampleClkQ;
  // A capture is taken from IDLE for a fresh edge or for one that arrived
  // while the previous frame was still being scanned.
  assign w_capture = (r_state == IDLE) && (w_rise || r_pending);

  // State register for the scan sequencer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: IDLE -> SCAN for eight cycles -> COMMIT -> IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_capture) w_nextState = SCAN;
      SCAN:    if (r_idx == 3'd7) w_nextState = COMMIT;
      COMMIT:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Magnitude of the selected snapshot channel. The most negative value has
  // no positive twin in W bits, so it saturates to the largest magnitude.
  // For every other negative value, only the low W-1 bits of the negation
  // are needed, because the magnitude fits in W-1 bits.
  always_comb begin
    w_x      = r_snap[r_idx];
    w_negLow = ~w_x[W-2:0] + {{(W-2){1'b0}}, 1'b1};
    w_mag    = w_x[W-2:0];
    if (w_x[W-1]) begin
      if (w_x[W-2:0] == '0) begin
        w_mag = '1;
      end else begin
        w_mag = w_negLow;
      end
    end
  end

  // Exponential decay step with a floor of one LSB. The floor lets a small
  // peak still reach zero. The step never exceeds the peak, so the
  // subtraction cannot wrap.
  always_comb begin
    w_peakCur = r_peak[r_idx];
    w_shift   = w_peakCur >> DECAY_SHIFT;
    w_step    = w_shift;
    if (w_shift == '0) begin
      w_step = {{(W-2){1'b0}}, 1'b1};
    end
    w_decayed = w_peakCur - w_step;
  end

  // Edge tracking, pending/overrun bookkeeping, snapshot capture, the
  // per-channel peak update during SCAN, and the all-at-once LED commit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sampleClkQ <= 1'b0;
      r_pending    <= 1'b0;
      r_overrun    <= 1'b0;
      r_idx        <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        r_snap[i] <= '0;
        r_peak[i] <= '0;
        r_led[i]  <= '0;
`ifdef LED_METER_PEAK_HOLD_EN
        r_hold[i] <= '0;
`endif
      end
    end else begin
      r_sampleClkQ <= i_sample_clk;

      if (r_state == IDLE) begin
        if (w_capture) begin
          r_snap[0] <= i_in0;
          r_snap[1] <= i_in1;
          r_snap[2] <= i_in2;
          r_snap[3] <= i_in3;
          r_snap[4] <= i_in4;
          r_snap[5] <= i_in5;
          r_snap[6] <= i_in6;
          r_snap[7] <= i_in7;
          r_idx     <= 3'd0;
          // A fresh edge that arrives in the same cycle a pending edge is
          // consumed stays pending for the following frame.
          r_pending <= r_pending & w_rise;
        end
      end else if (w_rise) begin
        if (r_pending) begin
          r_overrun <= 1'b1;
        end else begin
          r_pending <= 1'b1;
        end
      end

      if (r_state == SCAN) begin
        r_idx <= r_idx + 3'd1;
`ifdef LED_METER_PEAK_HOLD_EN
        if (w_mag >= w_peakCur) begin
          r_peak[r_idx] <= w_mag;
          r_hold[r_idx] <= HW'(HOLD_SAMPLES);
        end else if (r_hold[r_idx] != '0) begin
          r_hold[r_idx] <= r_hold[r_idx] - 1'b1;
        end else if (w_peakCur != '0) begin
          r_peak[r_idx] <= w_decayed;
        end
`else
        // In this branch mag < peak, so the peak is nonzero and decays.
        if (w_mag >= w_peakCur) begin
          r_peak[r_idx] <= w_mag;
        end else begin
          r_peak[r_idx] <= w_decayed;
        end
`endif
      end

      if (r_state == COMMIT) begin
        for (int i = 0; i < 8; i++) begin
          r_led[i] <= r_peak[i][W-2:W-9];
        end
      end
    end
  end

  assign o_led0    = r_led[0];
  assign o_led1    = r_led[1];
  assign o_led2    = r_led[2];
  assign o_led3    = r_led[3];
  assign o_led4    = r_led[4];
  assign o_led5    = r_led[5];
  assign o_led6    = r_led[6];
  assign o_led7    = r_led[7];
  assign o_busy    = (r_state != IDLE);
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_led_meter.sv
// ---------------------------------------------------------------------------
// tb_led_meter
//
// Directed bench for led_meter (W=16, HOLD_SAMPLES=2, DECAY_SHIFT=4).
// Expected values are hand-computed constants. Where the optional
// LED_METER_PEAK_HOLD_EN macro changes the expected results, both sets of
// values are given.
// A "cycle" begins at a rising clock edge. Inputs are driven and outputs
// are sampled 1 ns after that edge.
// ---------------------------------------------------------------------------
module tb_led_meter;

  logic               clk = 1'b0;
  logic               rst;
  logic               sampleClk;
  logic signed [15:0] tbIn [8];
  logic [7:0]         led0, led1, led2, led3, led4, led5, led6, led7;
  logic               busy;
  logic               overrun;

  int nChecks = 0;
  int nPassed = 0;
  int nFailed = 0;

  int expPeak0 [7];
  int expPeak1 [7];

  led_meter #(
    .W(16),
    .HOLD_SAMPLES(2),
    .DECAY_SHIFT(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_sample_clk(sampleClk),
    .i_in0(tbIn[0]),
    .i_in1(tbIn[1]),
    .i_in2(tbIn[2]),
    .i_in3(tbIn[3]),
    .i_in4(tbIn[4]),
    .i_in5(tbIn[5]),
    .i_in6(tbIn[6]),
    .i_in7(tbIn[7]),
    .o_led0(led0),
    .o_led1(led1),
    .o_led2(led2),
    .o_led3(led3),
    .o_led4(led4),
    .o_led5(led5),
    .o_led6(led6),
    .o_led7(led7),
    .o_busy(busy),
    .o_overrun(overrun)
  );

  // 100 MHz-style bench clock; only the cycle count matters.
  always #5 clk = ~clk;

  function automatic logic [7:0] ledOf(input int i);
    case (i)
      0: return led0;
      1: return led1;
      2: return led2;
      3: return led3;
      4: return led4;
      5: return led5;
      6: return led6;
      default: return led7;
    endcase
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) nPassed++;
    else begin
      nFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setInputs(input int v0, input int v1, input int v2, input int v3,
                           input int v4, input int v5, input int v6, input int v7);
    tbIn[0] = 16'(v0);
    tbIn[1] = 16'(v1);
    tbIn[2] = 16'(v2);
    tbIn[3] = 16'(v3);
    tbIn[4] = 16'(v4);
    tbIn[5] = 16'(v5);
    tbIn[6] = 16'(v6);
    tbIn[7] = 16'(v7);
  endtask

  // Wait for the scan to end, with a cycle budget.
  task automatic waitIdle();
    for (int n = 0; n < 20; n++) begin
      if (!busy) break;
      nextCycle();
    end
    checkOutput("scan_timeout", busy, 1'b0);
  endtask

  // Apply one snapshot, pulse sample_clk for one cycle, and wait for commit.
  task automatic applyStimulus(input int v0, input int v1, input int v2, input int v3,
                               input int v4, input int v5, input int v6, input int v7);
    setInputs(v0, v1, v2, v3, v4, v5, v6, v7);
    sampleClk = 1'b1;
    nextCycle();
    sampleClk = 1'b0;
    waitIdle();
  endtask

  task automatic pulseReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) nextCycle();
    rst = 1'b0;
    nextCycle();
  endtask

  initial begin
`ifdef LED_METER_PEAK_HOLD_EN
    expPeak0 = '{32767, 32767, 32767, 30720, 28800, 27000, 25313};
    expPeak1 = '{5, 5, 5, 4, 3, 2, 1};
`else
    expPeak0 = '{32767, 30720, 28800, 27000, 25313, 23731, 22248};
    expPeak1 = '{5, 4, 3, 2, 1, 0, 0};
`endif

    // Reset with nonzero inputs.
    rst       = 1'b1;
    sampleClk = 1'b0;
    setInputs(1234, -1234, 500, 77, 32767, -32768, 9, 4096);
    repeat (3) nextCycle();
    for (int i = 0; i < 8; i++) checkOutput($sformatf("led%0d_rst", i), ledOf(i), 8'h00);
    checkOutput("busy_rst", busy, 1'b0);
    checkOutput("overrun_rst", overrun, 1'b0);
    rst = 1'b0;
    nextCycle();
    checkOutput("busy_idle", busy, 1'b0);

    // Capture and latency: rise in cycle 0, new LEDs visible in cycle 10.
    $display("[TB] latency test");
    setInputs(16384, 0, 0, 0, 0, 0, 0, 0);
    sampleClk = 1'b1;
    checkOutput("busy_c0", busy, 1'b0);
    nextCycle();
    sampleClk = 1'b0;
    checkOutput("busy_c1", busy, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      checkOutput($sformatf("led0_c%0d", c), led0, 8'h00);
      if (c == 9) checkOutput("busy_c9", busy, 1'b1);
      nextCycle();
    end
    checkOutput("led0_c10", led0, 8'h80);
    for (int i = 1; i < 8; i++) checkOutput($sformatf("led%0d_c10", i), ledOf(i), 8'h00);
    checkOutput("busy_c10", busy, 1'b0);

    // Saturation and sign handling. Channel 0 now sees a zero sample.
    $display("[TB] saturation test");
    applyStimulus(0, 0, 0, -32768, 0, -256, 0, 0);
    checkOutput("led3_sat", led3, 8'hFF);
    checkOutput("led5_neg", led5, 8'h02);
`ifdef LED_METER_PEAK_HOLD_EN
    checkOutput("led0_held", led0, 8'h80);
`else
    checkOutput("led0_decay", led0, 8'h78);
`endif

    // Reset clears published LEDs.
    pulseReset(3);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("led%0d_rst2", i), ledOf(i), 8'h00);
    checkOutput("overrun_rst2", overrun, 1'b0);

    // Hold and decay of a large peak and a small peak.
    $display("[TB] hold/decay test");
    for (int f = 0; f < 7; f++) begin
      if (f == 0) applyStimulus(32767, 5, 0, 0, 0, 0, 0, 0);
      else        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("peak0_f%0d", f), dut.r_peak[0], expPeak0[f]);
      checkOutput($sformatf("peak1_f%0d", f), dut.r_peak[1], expPeak1[f]);
      checkOutput($sformatf("led0_f%0d", f), led0, expPeak0[f] >> 7);
    end

    // Overrun: pulses in cycles 0, 3 and 5.
    $display("[TB] overrun test");
    pulseReset(1);
    setInputs(16384, 0, 0, 0, 0, 0, 0, 0);
    sampleClk = 1'b1;
    checkOutput("overrun_c0", overrun, 1'b0);
    nextCycle();
    sampleClk = 1'b0;
    nextCycle();
    nextCycle();
    sampleClk = 1'b1;
    nextCycle();
    sampleClk = 1'b0;
    nextCycle();
    sampleClk = 1'b1;
    checkOutput("overrun_c5", overrun, 1'b0);
    nextCycle();
    sampleClk = 1'b0;
    checkOutput("overrun_c6", overrun, 1'b1);
    tbIn[0] = 16'sd32767;
    repeat (4) nextCycle();
    checkOutput("busy_ovr_c10", busy, 1'b0);
    checkOutput("led0_ovr_c10", led0, 8'h80);
    nextCycle();
    checkOutput("busy_ovr_c11", busy, 1'b1);
    waitIdle();
    checkOutput("led0_ovr_second", led0, 8'hFF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("overrun_sticky", overrun, 1'b1);
    pulseReset(1);
    checkOutput("overrun_cleared", overrun, 1'b0);

    // Reset in the middle of a scan discards the partial frame.
    $display("[TB] mid-scan reset test");
    setInputs(32767, 0, 0, 0, 0, 0, 0, 0);
    sampleClk = 1'b1;
    nextCycle();
    sampleClk = 1'b0;
    repeat (3) nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    checkOutput("busy_after_rst", busy, 1'b0);
    repeat (8) nextCycle();
    checkOutput("led0_after_rst", led0, 8'h00);
    checkOutput("busy_after_wait", busy, 1'b0);
    applyStimulus(32767, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("led0_rescan", led0, 8'hFF);

    $display("[TB] %0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule

// File: doc/led_meter.md
Name: led_meter

Overview:
- Peak-hold level meter between the calibrated sample buses and the I2C LED driver; one instance per board.
- Snapshots 8 channels (4 calibrated inputs, 4 calibrated outputs) on each sample_clk rising edge and tracks a per-channel peak magnitude with hold and exponential decay.
- Produces 8-bit unsigned brightness values for the pmod_i2c_master led0..led7 ports.
- Channels are processed one per clk cycle through a shared magnitude/compare/decay datapath.

Parameters:
- W, 16, sample width in bits (signed two's complement).
- HOLD_SAMPLES, 4800, sample periods a new peak is held before decay starts (100 ms at 48 kHz).
- DECAY_SHIFT, 4, decay per sample period = peak >> DECAY_SHIFT, minimum 1.

Ports:
- clk  in  1  system clock (12 MHz domain).
- rst  in  1  reset.
- sample_clk  in  1  sample-rate clock from the CODEC block, same clk domain, level signal.
- in0..in7  in  W each, signed; in0..3 = calibrated inputs, in4..7 = calibrated outputs.
- led0..led7  out  8 each, unsigned brightness per channel.
- busy  out  1  high while a scan is in progress.
- overrun  out  1  sticky: a sample_clk edge arrived while one was already pending.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. On rst: all peaks = 0, hold counters = 0, led0..7 = 0, busy = 0, overrun = 0, pending = 0, state = IDLE, sample_clk edge register = 0.
- Edge detect: sample_clk is registered once; rise = sample_clk & ~sample_clk_q.
- FSM states are IDLE, SCAN, COMMIT.
  - IDLE: on rise (or pending set), capture in0..in7 into a snapshot register, clear pending, set idx = 0, go to SCAN.
  - SCAN: one channel per cycle, idx 0..7; after idx 7, go to COMMIT.
  - COMMIT: led[i] = peak[i][W-2:W-9] for all i simultaneously; go to IDLE.
- Latency: rise at cycle 0 (capture), SCAN cycles 1..8, COMMIT at cycle 9, new led values visible at cycle 10. busy = 1 in SCAN and COMMIT.
- Magnitude: mag = |x|; -2^(W-1) saturates to 2^(W-1)-1; mag width is W-1 bits.
- Per-channel update in SCAN, in priority order:
  - mag >= peak: peak = mag, hold = HOLD_SAMPLES.
  - else hold > 0: hold = hold - 1, peak unchanged.
  - else peak > 0: peak = peak - max(peak >> DECAY_SHIFT, 1), never below 0.
  - else: peak stays 0.
- Hold counter width is $clog2(HOLD_SAMPLES+1).
- Rise during SCAN or COMMIT: set pending; the snapshot is not updated until the next IDLE capture. That pending edge is processed by capture directly from IDLE.
- Rise while pending is already set: overrun = 1 (sticky until rst); the extra edge is dropped.
- Rise in the same cycle as COMMIT: counts as pending, processed next cycle.
- rst mid-scan: immediate return to reset state; partial updates are discarded.
- led outputs change only in COMMIT; they never show a partially scanned frame.

Optional Feature:
- Macro: LED_METER_PEAK_HOLD_EN.
- Defined: hold counters and HOLD_SAMPLES behave as above.
- Undefined: no hold counters are instantiated; HOLD_SAMPLES is ignored; when mag < peak, decay applies on every sample period, including the period right after a new peak.

Test Plan:
- Reset: assert rst for 3 cycles with inputs nonzero -> led0..7 = 0, busy = 0, overrun = 0; busy rises exactly 1 cycle after the first rise following reset release.
- Capture/latency: in0 = 16384, others 0, one rise -> at cycle 10, led0 = 0x80 and led1..7 = 0; led0 unchanged at cycles 1..9.
- Saturation and sign: in3 = -32768, in5 = -256 -> led3 = 0xFF, led5 = 0x02.
- Hold then decay (HOLD_SAMPLES = 2, DECAY_SHIFT = 4, macro defined): in0 = 32767 once, then 0 -> peak0 stays 32767 for 2 further samples, then 30720, 28800; with macro undefined, the first zero sample gives 30720. Small peak 5 decays 4, 3, 2, 1, 0 and stays 0.
- Overrun: pulse sample_clk at cycles 0, 3 and 5 -> cycle-3 rise is pending and captured at cycle 10; cycle-5 rise sets overrun = 1, which persists until rst.
- Reset mid-scan: rst at cycle 4 of a scan with in0 = 32767 -> led0 remains 0, FSM in IDLE; the next rise scans normally.
